// File: rtl/stats_pkg.sv
// Shared encodings for the statistics update sequencer: FSM states,
// CPU read-select codes and FIFO grant values.
package stats_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADD_OCT = 3'd3,
        ST_ADD_PKT = 3'd4
    } stats_state_e;

    localparam logic [1:0] STATS_SEL_TX_PKT = 2'd0;
    localparam logic [1:0] STATS_SEL_TX_OCT = 2'd1;
    localparam logic [1:0] STATS_SEL_RX_PKT = 2'd2;
    localparam logic [1:0] STATS_SEL_RX_OCT = 2'd3;

    typedef enum logic {
        GNT_TX = 1'b0,
        GNT_RX = 1'b1
    } stats_gnt_e;

endpackage

// File: rtl/stats_update_ctrl_if.sv
// FIFO read-side and CPU register-port bundle for stats_update_ctrl.
// master = the sequencer, slave = FIFOs plus register block.
interface stats_update_ctrl_if #(
    parameter int CNT_WIDTH = 32,
    parameter int LEN_WIDTH = 14
);
    logic [LEN_WIDTH-1:0] txsfifo_rdata;
    logic                 txsfifo_rempty;
    logic                 txsfifo_ren;
    logic [LEN_WIDTH-1:0] rxsfifo_rdata;
    logic                 rxsfifo_rempty;
    logic                 rxsfifo_ren;
    logic                 stats_clear;
    logic [1:0]           stats_rd_sel;
    logic [CNT_WIDTH-1:0] stats_rd_data;
    logic                 stats_busy;

    modport master (
        input  txsfifo_rdata, txsfifo_rempty, rxsfifo_rdata, rxsfifo_rempty,
        input  stats_clear, stats_rd_sel,
        output txsfifo_ren, rxsfifo_ren, stats_rd_data, stats_busy
    );

    modport slave (
        output txsfifo_rdata, txsfifo_rempty, rxsfifo_rdata, rxsfifo_rempty,
        output stats_clear, stats_rd_sel,
        input  txsfifo_ren, rxsfifo_ren, stats_rd_data, stats_busy
    );

endinterface

// File: rtl/stats_counter.sv
// One statistics counter register with clear, write-enable and next value.
// STATS_SATURATE_EN makes a carry-out from the shared adder clamp to all-ones.
module stats_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 we,
    input  logic                 carry,
    input  logic [CNT_WIDTH-1:0] nxt,
    output logic [CNT_WIDTH-1:0] value
);

    logic [CNT_WIDTH-1:0] wr_value;

`ifdef STATS_SATURATE_EN
    assign wr_value = carry ? '1 : nxt;
`else
    logic unused_carry;
    assign unused_carry = carry;
    assign wr_value     = nxt;
`endif

    // Clear wins over a same-cycle write so no partial sample survives it.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            value <= '0;
        end else if (we) begin
            value <= wr_value;
        end
    end

endmodule

// File: rtl/stats_update_ctrl.sv
// Drains the TX/RX stats FIFOs round-robin and updates four counters through
// one shared adder; registered CPU read port. Optional macro: STATS_SATURATE_EN.
module stats_update_ctrl
    import stats_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int LEN_WIDTH = 14
) (
    input  logic                wb_clk_i,
    input  logic                reset_wb_n,
    stats_update_ctrl_if.master bus
);

    stats_state_e         state_q, state_d;
    stats_gnt_e           gnt_q, gnt_d, last_q, last_d, last_eff, arb_gnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 discard_q;
    logic                 ren_tx_q, ren_rx_q;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 req_tx, req_rx;

    logic [CNT_WIDTH-1:0] cnt [4];
    logic [3:0]           cnt_we;
    logic [1:0]           oct_idx, pkt_idx;
    logic [CNT_WIDTH-1:0] add_a, add_b, add_sum;
    logic                 add_carry;

    assign req_tx = !bus.txsfifo_rempty;
    assign req_rx = !bus.rxsfifo_rempty;

    // In ADD_PKT the current grant is about to become "last", so arbitrate against it.
    always_comb begin
        last_eff = (state_q == ST_ADD_PKT) ? gnt_q : last_q;
        arb_gnt  = GNT_RX;
        if (req_tx && req_rx) begin
            arb_gnt = (last_eff == GNT_TX) ? GNT_RX : GNT_TX;
        end else if (req_tx) begin
            arb_gnt = GNT_TX;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_tx || req_rx) begin
                    state_d = ST_POP;
                    gnt_d   = arb_gnt;
                end
            end
            ST_POP:     state_d = ST_WAIT;
            ST_WAIT:    state_d = discard_q ? ST_IDLE : ST_ADD_OCT;
            ST_ADD_OCT: state_d = ST_ADD_PKT;
            ST_ADD_PKT: begin
                last_d = gnt_q;
                if (req_tx || req_rx) begin
                    state_d = ST_POP;
                    gnt_d   = arb_gnt;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A clear after the pop has completed abandons the in-flight sample.
        if (bus.stats_clear && state_q != ST_IDLE && state_q != ST_POP) begin
            state_d = ST_IDLE;
            gnt_d   = gnt_q;
            last_d  = last_q;
        end
    end

    always_comb begin
        oct_idx = (gnt_q == GNT_TX) ? STATS_SEL_TX_OCT : STATS_SEL_RX_OCT;
        pkt_idx = (gnt_q == GNT_TX) ? STATS_SEL_TX_PKT : STATS_SEL_RX_PKT;
        add_a   = (state_q == ST_ADD_OCT) ? cnt[oct_idx] : cnt[pkt_idx];
        add_b   = (state_q == ST_ADD_OCT) ? CNT_WIDTH'(len_q) : CNT_WIDTH'(1);
        {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};
        cnt_we  = 4'b0000;
        if (state_q == ST_ADD_OCT) begin
            cnt_we[oct_idx] = 1'b1;
        end else if (state_q == ST_ADD_PKT) begin
            cnt_we[pkt_idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        stats_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (wb_clk_i),
            .rst_n (reset_wb_n),
            .clr   (bus.stats_clear),
            .we    (cnt_we[i]),
            .carry (add_carry),
            .nxt   (add_sum),
            .value (cnt[i])
        );
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset_wb_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_TX;
            last_q    <= GNT_RX;
            len_q     <= '0;
            discard_q <= 1'b0;
            ren_tx_q  <= 1'b0;
            ren_rx_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            discard_q <= (state_q == ST_POP) && bus.stats_clear;
            if (state_q == ST_WAIT) begin
                len_q <= (gnt_q == GNT_TX) ? bus.txsfifo_rdata : bus.rxsfifo_rdata;
            end
            ren_tx_q  <= (state_d == ST_POP) && (gnt_d == GNT_TX);
            ren_rx_q  <= (state_d == ST_POP) && (gnt_d == GNT_RX);
            rd_data_q <= bus.stats_clear ? '0 : cnt[bus.stats_rd_sel];
        end
    end

    assign bus.txsfifo_ren   = ren_tx_q;
    assign bus.rxsfifo_ren   = ren_rx_q;
    assign bus.stats_rd_data = rd_data_q;
    assign bus.stats_busy    = (state_q != ST_IDLE);

endmodule
